// File: rtl/ft_lockstep_cmp_if.sv
// ---------------------------------------------------------------------------
// ft_lockstep_cmp_if
//   Bundle of every non-clock signal between the lockstep cores / memory
//   select logic and the lockstep comparator.
//
//   Parameters
//     NCORES  number of lockstep cores (2 = DMR, 3 = TMR)
//     AW      register address width
//     DW      register data width
//
//   Signals (direction as seen from the comparator)
//     enable_i         comparator enable; low flushes FIFOs, no checking
//     we_i             per-core regfile write enable
//     waddr_i          per-core write address, core k at [k*AW +: AW]
//     wdata_i          per-core write data,    core k at [k*DW +: DW]
//     pc_i             PC of core 0
//     done_i           recovery complete, from the cores
//     recover_o        recovery request to the cores
//     reset_o          core reset pulse
//     recovering_o     selects the FTM memory path
//     error_o          one-cycle pulse on any detected mismatch
//     fault_core_o     sticky per-core fault flags (TMR)
//     timeout_o        sticky recovery-timeout flag
//     checkpoint_pc_o  pc_i captured at the last fully matching compare
//     mismatch_cnt_o   saturating mismatch counter (0 when stats disabled)
//
//   Modports
//     slave   the comparator
//     master  the cores / surrounding system (or a testbench)
// ---------------------------------------------------------------------------
interface ft_lockstep_cmp_if #(
  parameter int NCORES = 2,
  parameter int AW     = 5,
  parameter int DW     = 32
);

  logic                   enable_i;
  logic [NCORES-1:0]      we_i;
  logic [NCORES*AW-1:0]   waddr_i;
  logic [NCORES*DW-1:0]   wdata_i;
  logic [31:0]            pc_i;
  logic                   done_i;

  logic                   recover_o;
  logic                   reset_o;
  logic                   recovering_o;
  logic                   error_o;
  logic [NCORES-1:0]      fault_core_o;
  logic                   timeout_o;
  logic [31:0]            checkpoint_pc_o;
  logic [15:0]            mismatch_cnt_o;

  modport slave (
    input  enable_i, we_i, waddr_i, wdata_i, pc_i, done_i,
    output recover_o, reset_o, recovering_o, error_o, fault_core_o,
           timeout_o, checkpoint_pc_o, mismatch_cnt_o
  );

  modport master (
    output enable_i, we_i, waddr_i, wdata_i, pc_i, done_i,
    input  recover_o, reset_o, recovering_o, error_o, fault_core_o,
           timeout_o, checkpoint_pc_o, mismatch_cnt_o
  );

endinterface

// File: rtl/ft_lockstep_cmp.sv
// ---------------------------------------------------------------------------
// ft_lockstep_cmp
//   Lockstep writeback comparator for NCORES cores (2 = DMR, 3 = TMR).
//   Each core's regfile writebacks are queued in a per-core skew FIFO; when
//   every FIFO holds an entry, all heads pop together and are compared.
//   A major mismatch (or a skew-FIFO overflow) starts the recovery
//   handshake; in TMR a single outvoted core is only flagged.
//
//   Optional feature: define FT_CMP_STATS_EN to implement the saturating
//   mismatch counter; otherwise mismatch_cnt_o is tied to 0.
//
//   Parameters
//     NCORES   2 or 3
//     DEPTH    entries per skew FIFO (power of 2, >= 2)
//     AW, DW   register address / data width
//     TIMEOUT  cycles to wait in RECOVER for done_i before giving up
//
//   Ports
//     clk_i    clock
//     rst_i    synchronous active-high reset
//     lk       ft_lockstep_cmp_if.slave (writeback streams, handshake,
//              status outputs)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal checking, pushes and compares enabled
//   RECOVER  | recover_o/recovering_o high, wait for done_i or timeout
//   RESET    | reset_o high for two cycles
//   FLUSH    | one cycle, every skew FIFO emptied, then back to RUN
// ---------------------------------------------------------------------------
module ft_lockstep_cmp #(
  parameter int NCORES  = 2,
  parameter int DEPTH   = 4,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ft_lockstep_cmp_if.slave lk
);

  localparam int EW = AW + DW;
  localparam int AB = $clog2(DEPTH);
  localparam int PW = AB + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_RECOVER = 2'd1,
    S_RESET   = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] tmr_q;
  logic          set_timeout;

  logic run_ok;
  logic flush;
  logic pop;
  logic ovf_any;

  logic [NCORES-1:0]         empty;
  logic [NCORES-1:0]         ovf;
  logic [NCORES-1:0][EW-1:0] head;

  logic              cmp_match, cmp_minor, cmp_major;
  logic [NCORES-1:0] cmp_fault;

  logic              match_q, minor_q, major_q;
  logic [NCORES-1:0] fault_hit_q;
  logic [NCORES-1:0] fault_q;
  logic              timeout_q;
  logic [31:0]       checkpoint_q;

  logic recover, reset_pls, recovering;

  // A pending major result blocks further pushes/pops so only one result
  // is acted on before recovery takes over.
  assign run_ok  = (state_q == S_RUN) && lk.enable_i && !major_q;
  assign flush   = !lk.enable_i || (state_q == S_FLUSH);
  assign pop     = run_ok && !(|empty);
  assign ovf_any = |ovf;

  // -------------------------------------------------------------------------
  // Per-core skew FIFOs
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NCORES; k++) begin : g_core
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          full;
    logic          wr_req;
    logic          push;

    assign addr = lk.waddr_i[k*AW +: AW];
    assign data = lk.wdata_i[k*DW +: DW];

    assign empty[k] = (wp_q == rp_q);
    assign full     = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[AB-1:0] == rp_q[AB-1:0]);

    // x0 writes carry no architectural state and are dropped.
    assign wr_req = run_ok && lk.we_i[k] && (addr != '0);
    // A pop in the same cycle frees the head slot, so a full FIFO may accept.
    assign push   = wr_req && (!full || pop);
    assign ovf[k] = wr_req && full && !pop;

    assign head[k] = mem_q[rp_q[AB-1:0]];

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem_q[wp_q[AB-1:0]] <= {addr, data};
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) begin
          wp_q <= wp_q + 1'b1;
        end
        if (pop) begin
          rp_q <= rp_q + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Head comparison / vote
  // -------------------------------------------------------------------------
  if (NCORES == 2) begin : g_dmr
    always_comb begin
      cmp_match = (head[0] == head[1]);
      cmp_major = !cmp_match;
      cmp_minor = 1'b0;
      cmp_fault = '0;
    end
  end else begin : g_tmr
    logic e01, e02, e12;

    assign e01 = (head[0] == head[1]);
    assign e02 = (head[0] == head[2]);
    assign e12 = (head[1] == head[2]);

    always_comb begin
      cmp_match = 1'b0;
      cmp_minor = 1'b0;
      cmp_major = 1'b0;
      cmp_fault = '0;
      if (e01 && e02) begin
        cmp_match = 1'b1;
      end else if (e01) begin
        cmp_minor    = 1'b1;
        cmp_fault[2] = 1'b1;
      end else if (e02) begin
        cmp_minor    = 1'b1;
        cmp_fault[1] = 1'b1;
      end else if (e12) begin
        cmp_minor    = 1'b1;
        cmp_fault[0] = 1'b1;
      end else begin
        cmp_major = 1'b1;
      end
    end
  end

  // Registered compare result. An overflow in the same cycle is a major
  // event and overrides any match/minor outcome of the compare.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      match_q     <= 1'b0;
      minor_q     <= 1'b0;
      major_q     <= 1'b0;
      fault_hit_q <= '0;
    end else begin
      match_q     <= pop && cmp_match && !ovf_any;
      minor_q     <= pop && cmp_minor && !ovf_any;
      major_q     <= (pop && cmp_major) || ovf_any;
      fault_hit_q <= (pop && cmp_minor && !ovf_any) ? cmp_fault : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky status and checkpoint
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_q      <= '0;
      timeout_q    <= 1'b0;
      checkpoint_q <= '0;
    end else begin
      fault_q <= fault_q | fault_hit_q;
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end
      if (match_q) begin
        checkpoint_q <= lk.pc_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Recovery FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      // Cycle counter restarts at 0 on every state entry.
      if ((state_d != state_q) || (state_q == S_RUN) || (state_q == S_FLUSH)) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    set_timeout = 1'b0;
    case (state_q)
      S_RUN: begin
        if (major_q) begin
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (lk.done_i) begin
          state_d = S_RESET;
        end else if (tmr_q == CW'(TIMEOUT - 1)) begin
          // tmr_q+1 reaches TIMEOUT on this edge: TIMEOUT cycles spent here.
          state_d     = S_RESET;
          set_timeout = 1'b1;
        end
      end
      S_RESET: begin
        if (tmr_q == CW'(1)) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    recover    = 1'b0;
    reset_pls  = 1'b0;
    recovering = 1'b0;
    case (state_q)
      S_RECOVER: begin
        recover    = 1'b1;
        recovering = 1'b1;
      end
      S_RESET: begin
        reset_pls = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Mismatch statistics
  // -------------------------------------------------------------------------
`ifdef FT_CMP_STATS_EN
  logic [15:0] mcnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcnt_q <= '0;
    end else if ((major_q || minor_q) && (mcnt_q != 16'hFFFF)) begin
      mcnt_q <= mcnt_q + 16'd1;
    end
  end

  assign lk.mismatch_cnt_o = mcnt_q;
`else
  assign lk.mismatch_cnt_o = '0;
`endif

  assign lk.recover_o       = recover;
  assign lk.reset_o         = reset_pls;
  assign lk.recovering_o    = recovering;
  assign lk.error_o         = major_q || minor_q;
  assign lk.fault_core_o    = fault_q;
  assign lk.timeout_o       = timeout_q;
  assign lk.checkpoint_pc_o = checkpoint_q;

endmodule

// File: tb/tb_ft_lockstep_cmp.sv
// ---------------------------------------------------------------------------
// tb_ft_lockstep_cmp
//   Directed bench for ft_lockstep_cmp: one DMR instance (b2/u_dmr) and one
//   TMR instance (b3/u_tmr) sharing clock and reset. Inputs change 1 time
//   unit after the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ft_lockstep_cmp;

`ifdef FT_CMP_STATS_EN
  localparam int EXP_MCNT = 3;
`else
  localparam int EXP_MCNT = 0;
`endif

  logic clk;
  logic rst;

  int n_chk  = 0;
  int n_pass = 0;
  int e2_cnt = 0;
  int e3_cnt = 0;

  ft_lockstep_cmp_if #(.NCORES(2), .AW(5), .DW(32)) b2 ();
  ft_lockstep_cmp_if #(.NCORES(3), .AW(5), .DW(32)) b3 ();

  ft_lockstep_cmp #(.NCORES(2), .DEPTH(4), .AW(5), .DW(32), .TIMEOUT(255)) u_dmr (
    .clk_i (clk),
    .rst_i (rst),
    .lk    (b2)
  );

  ft_lockstep_cmp #(.NCORES(3), .DEPTH(4), .AW(5), .DW(32), .TIMEOUT(255)) u_tmr (
    .clk_i (clk),
    .rst_i (rst),
    .lk    (b3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b2.error_o === 1'b1) e2_cnt++;
    if (b3.error_o === 1'b1) e3_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1);
    b2.we_i    = we;
    b2.waddr_i = {a1, a0};
    b2.wdata_i = {d1, d0};
    tick();
    b2.we_i    = '0;
  endtask

  task automatic wr3(input logic [2:0] we, input logic [4:0] a, input logic [31:0] d0,
                     input logic [31:0] d1, input logic [31:0] d2);
    b3.we_i    = we;
    b3.waddr_i = {a, a, a};
    b3.wdata_i = {d2, d1, d0};
    tick();
    b3.we_i    = '0;
  endtask

  // Called while the selected DUT sits in RECOVER: assert done_i and walk
  // through the two-cycle reset pulse, the flush cycle, back into RUN.
  task automatic finish_rec(input bit tmr);
    if (tmr) b3.done_i = 1'b1;
    else     b2.done_i = 1'b1;
    tick();
    b2.done_i = 1'b0;
    b3.done_i = 1'b0;
    chk("rst_pulse_1",    tmr ? b3.reset_o      : b2.reset_o,      1);
    chk("rst_recovering", tmr ? b3.recovering_o : b2.recovering_o, 0);
    chk("rst_recover",    tmr ? b3.recover_o    : b2.recover_o,    0);
    tick();
    chk("rst_pulse_2",    tmr ? b3.reset_o      : b2.reset_o,      1);
    tick();
    chk("rst_pulse_end",  tmr ? b3.reset_o      : b2.reset_o,      0);
    tick();
  endtask

  initial begin
    int e0;
    int n;

    clk = 1'b0;
    rst = 1'b1;
    b2.enable_i = 1'b1; b2.we_i = '0; b2.waddr_i = '0; b2.wdata_i = '0;
    b2.pc_i = 32'h0; b2.done_i = 1'b0;
    b3.enable_i = 1'b1; b3.we_i = '0; b3.waddr_i = '0; b3.wdata_i = '0;
    b3.pc_i = 32'h0; b3.done_i = 1'b0;
    repeat (3) tick();

    chk("reset_recover",    b2.recover_o,       0);
    chk("reset_reset",      b2.reset_o,         0);
    chk("reset_recovering", b2.recovering_o,    0);
    chk("reset_error",      b2.error_o,         0);
    chk("reset_timeout",    b2.timeout_o,       0);
    chk("reset_cp",         b2.checkpoint_pc_o, 0);
    chk("reset_fault3",     b3.fault_core_o,    0);
    chk("reset_mcnt",       b2.mismatch_cnt_o,  0);
    rst = 1'b0;
    tick();

    // DMR matching writeback: checkpoint two cycles after sampling.
    b2.pc_i = 32'h80;
    wr2(2'b11, 5'd5, 32'h1234, 5'd5, 32'h1234);
    tick();
    chk("match_err",      b2.error_o,         0);
    chk("match_cp_early", b2.checkpoint_pc_o, 0);
    tick();
    chk("match_cp",       b2.checkpoint_pc_o, 32'h80);
    chk("match_recover",  b2.recover_o,       0);

    // DMR data mismatch -> recovery, done_i after 10 RECOVER cycles.
    b2.pc_i = 32'h90;
    wr2(2'b11, 5'd5, 32'h1234, 5'd5, 32'h1235);
    tick();
    chk("mm_err_pulse",   b2.error_o,   1);
    chk("mm_recover_e1",  b2.recover_o, 0);
    tick();
    chk("mm_err_end",     b2.error_o,      0);
    chk("mm_recover",     b2.recover_o,    1);
    chk("mm_recovering",  b2.recovering_o, 1);
    chk("mm_cp_hold",     b2.checkpoint_pc_o, 32'h80);
    wr2(2'b11, 5'd6, 32'h1, 5'd6, 32'h2);      // ignored in RECOVER
    repeat (8) tick();
    chk("mm_recover_10",  b2.recover_o, 1);
    finish_rec(1'b0);
    e0 = e2_cnt;
    b2.pc_i = 32'hA0;
    wr2(2'b11, 5'd8, 32'h55, 5'd8, 32'h55);
    tick();
    tick();
    chk("mm_after_cp",    b2.checkpoint_pc_o, 32'hA0);
    chk("mm_after_noerr", 64'(e2_cnt - e0), 0);

    // Core1 lags by 4 writes (FIFO exactly full), then push+pop on full.
    e0 = e2_cnt;
    b2.pc_i = 32'hB0;
    for (int i = 1; i <= 4; i++) wr2(2'b01, 5'(i), 32'h100 + 32'(i), 5'd0, 32'h0);
    wr2(2'b10, 5'd0, 32'h0, 5'd1, 32'h101);
    wr2(2'b11, 5'd5, 32'h105, 5'd2, 32'h102);
    for (int i = 3; i <= 5; i++) wr2(2'b10, 5'd0, 32'h0, 5'(i), 32'h100 + 32'(i));
    repeat (3) tick();
    chk("lag_noerr",  64'(e2_cnt - e0), 0);
    chk("lag_cp",     b2.checkpoint_pc_o, 32'hB0);
    chk("lag_no_rec", b2.recover_o, 0);

    // Lag of 5 writes: fifth push overflows -> major recovery.
    for (int i = 1; i <= 5; i++) wr2(2'b01, 5'(i), 32'h200 + 32'(i), 5'd0, 32'h0);
    chk("ovf_err", b2.error_o, 1);
    tick();
    chk("ovf_recover", b2.recover_o, 1);
    finish_rec(1'b0);
    e0 = e2_cnt;
    b2.pc_i = 32'hC0;
    wr2(2'b11, 5'd9, 32'h77, 5'd9, 32'h77);
    tick();
    tick();
    chk("ovf_flushed_cp",    b2.checkpoint_pc_o, 32'hC0);
    chk("ovf_flushed_noerr", 64'(e2_cnt - e0), 0);

    // x0 write dropped; enable_i low empties the FIFOs.
    e0 = e2_cnt;
    wr2(2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0);
    wr2(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
    b2.enable_i = 1'b0;
    tick();
    b2.enable_i = 1'b1;
    b2.pc_i = 32'hD0;
    wr2(2'b11, 5'd4, 32'h44, 5'd4, 32'h44);
    tick();
    tick();
    chk("x0_en_cp",    b2.checkpoint_pc_o, 32'hD0);
    chk("x0_en_noerr", 64'(e2_cnt - e0), 0);

    // TMR: core2 outvoted -> minor only.
    b3.pc_i = 32'h300;
    wr3(3'b111, 5'd7, 32'hBEEF, 32'hBEEF, 32'hDEAD);
    tick();
    chk("tmr_err",      b3.error_o,   1);
    chk("tmr_rec_e1",   b3.recover_o, 0);
    tick();
    chk("tmr_fault",    b3.fault_core_o, 3'b100);
    chk("tmr_rec",      b3.recover_o,    0);
    chk("tmr_cp_none",  b3.checkpoint_pc_o, 0);
    b3.pc_i = 32'h310;
    wr3(3'b111, 5'd8, 32'h11, 32'h11, 32'h11);
    tick();
    tick();
    chk("tmr_match_cp", b3.checkpoint_pc_o, 32'h310);
    wr3(3'b111, 5'd9, 32'h22, 32'h21, 32'h21);
    tick();
    tick();
    chk("tmr_fault_c0", b3.fault_core_o, 3'b101);
    chk("tmr_rec_c0",   b3.recover_o,    0);
    wr3(3'b111, 5'd10, 32'h1, 32'h2, 32'h3);
    tick();
    chk("tmr_major_err", b3.error_o, 1);
    tick();
    chk("tmr_major_rec", b3.recover_o, 1);
    finish_rec(1'b1);

    // Timeout: done_i never arrives.
    wr2(2'b11, 5'd11, 32'h1, 5'd11, 32'h2);
    tick();
    tick();
    n = 0;
    while (b2.recover_o === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    chk("to_cycles",  64'(n), 255);
    chk("to_flag",    b2.timeout_o, 1);
    chk("to_reset_1", b2.reset_o,   1);
    tick();
    chk("to_reset_2", b2.reset_o,   1);
    tick();
    chk("to_reset_end", b2.reset_o, 0);
    tick();
    chk("to_sticky",  b2.timeout_o, 1);
    chk("to_run",     b2.recover_o, 0);

    // Reset asserted in the middle of RECOVER.
    wr2(2'b11, 5'd12, 32'h1, 5'd12, 32'h2);
    tick();
    tick();
    chk("mid_rec", b2.recover_o, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_recover",    b2.recover_o,       0);
    chk("mid_rst_recovering", b2.recovering_o,    0);
    chk("mid_rst_reset",      b2.reset_o,         0);
    chk("mid_rst_error",      b2.error_o,         0);
    chk("mid_rst_timeout",    b2.timeout_o,       0);
    chk("mid_rst_cp",         b2.checkpoint_pc_o, 0);
    chk("mid_rst_fault3",     b3.fault_core_o,    0);
    chk("mid_rst_mcnt3",      b3.mismatch_cnt_o,  0);
    rst = 1'b0;
    tick();
    b2.pc_i = 32'hE0;
    wr2(2'b11, 5'd13, 32'h9, 5'd13, 32'h9);
    tick();
    tick();
    chk("mid_rst_run_cp", b2.checkpoint_pc_o, 32'hE0);

    // Three minor events on TMR for the statistics counter.
    e0 = e3_cnt;
    for (int i = 1; i <= 3; i++) wr3(3'b111, 5'(i), 32'h5, 32'h6, 32'h5);
    repeat (3) tick();
    chk("stats_errs",  64'(e3_cnt - e0), 3);
    chk("stats_fault", b3.fault_core_o,  3'b010);
    chk("stats_rec",   b3.recover_o,     0);
    chk("stats_mcnt",  b3.mismatch_cnt_o, EXP_MCNT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
